i2c_eeprom_sequencer: RTL and testbench



---
 rtl/i2c_eeprom_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_eeprom_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_eeprom_sequencer.sv
// rtl/i2c_eeprom_sequencer.sv - sequences the I2C byte engine through 24Cxx sequential reads and page writes
module i2c_eeprom_sequencer #(
    parameter int HALF_PERIOD     = 240,
    parameter int TWR_CYCLES      = 120000,
    parameter int TIMEOUT_TOGGLES = 1024
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cmd_start,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [3:0] cmd_count,
    input  logic [2:0] dev_sel,
    input  logic       buf_wr_en,
    input  logic [3:0] buf_wr_addr,
    input  logic [7:0] buf_wr_data,
    input  logic [3:0] buf_rd_addr,
    output logic [7:0] buf_rd_data,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       eng_clock,
    output logic [7:0] eng_write_byte,
    output logic       eng_read_mode,
    output logic       eng_do_start,
    output logic       eng_expect_ack,
    output logic       eng_do_stop,
    input  logic [7:0] eng_read_byte,
    input  logic       eng_finished
);
    localparam int HW  = $clog2(HALF_PERIOD + 1);
    localparam int TGW = $clog2(TIMEOUT_TOGGLES + 1);
    localparam int TWW = $clog2(TWR_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_NEXT, S_TWR, S_DONE} state_t;

    state_t           state, state_d;
    logic [7:0]       addr_q;
    logic [3:0]       count_q;
    logic [2:0]       dev_q;
    logic             write_q;
    logic [3:0]       idx;
    logic [1:0]       op;
    logic [HW-1:0]    half_cnt;
    logic [TGW-1:0]   toggles;
    logic [TWW-1:0]   twr_cnt;
    logic [7:0]       wr_buf [16];
    logic [7:0]       rd_buf [16];

    logic             accept, half_expire, op_done, op_timeout, last_op, seq_end;
    logic [7:0]       op_byte;
    logic             op_read_mode, op_start, op_ack, op_stop;

    assign busy        = (state == S_LOAD) || (state == S_RUN) || (state == S_NEXT) || (state == S_TWR);
    assign done        = (state == S_DONE);
    assign buf_rd_data = rd_buf[buf_rd_addr];

    // The toggles>=2 guard skips the finished flag still set by the previous op.
    assign accept      = cmd_start && ((state == S_IDLE) || (state == S_DONE));
    assign half_expire = (half_cnt == '0);
    assign op_done     = half_expire && (toggles >= TGW'(2)) && eng_finished;
    assign op_timeout  = half_expire && !op_done && (toggles == TGW'(TIMEOUT_TOGGLES));
    assign seq_end     = write_q ? (op == 2'd2) : (op == 2'd3);
    assign last_op     = seq_end && (idx == count_q);

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (accept) state_d = S_LOAD;
            S_LOAD: state_d = S_RUN;
            S_RUN: begin
                if (op_done)         state_d = S_NEXT;
                else if (op_timeout) state_d = S_DONE;
            end
            S_NEXT: begin
                if (!last_op)     state_d = S_LOAD;
                else if (write_q) state_d = S_TWR;
                else              state_d = S_DONE;
            end
            S_TWR:  if (twr_cnt == '0) state_d = S_DONE;
            S_DONE: state_d = accept ? S_LOAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Write: devsel, addr, then data bytes. Read per byte: devsel(w), addr, devsel(r), data.
    always_comb begin
        op_byte      = 8'h00;
        op_read_mode = 1'b0;
        op_start     = 1'b0;
        op_ack       = 1'b0;
        op_stop      = 1'b0;
        case (op)
            2'd0: begin
                op_byte  = {4'b1010, dev_q, 1'b0};
                op_start = 1'b1;
                op_ack   = 1'b1;
            end
            2'd1: begin
                op_byte = addr_q;
                op_ack  = 1'b1;
            end
            2'd2: begin
                if (write_q) begin
                    op_byte = wr_buf[idx];
                    op_ack  = 1'b1;
                    op_stop = (idx == count_q);
                end else begin
                    op_byte  = {4'b1010, dev_q, 1'b1};
                    op_start = 1'b1;
                    op_ack   = 1'b1;
                end
            end
            default: begin
                op_read_mode = 1'b1;
                op_stop      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            error          <= 1'b0;
            eng_clock      <= 1'b0;
            eng_write_byte <= 8'h00;
            eng_read_mode  <= 1'b0;
            eng_do_start   <= 1'b0;
            eng_expect_ack <= 1'b0;
            eng_do_stop    <= 1'b0;
            addr_q         <= 8'h00;
            count_q        <= 4'h0;
            dev_q          <= 3'b000;
            write_q        <= 1'b0;
            idx            <= 4'h0;
            op             <= 2'd0;
            half_cnt       <= '0;
            toggles        <= '0;
            twr_cnt        <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                addr_q  <= cmd_addr;
                count_q <= cmd_count;
                dev_q   <= dev_sel;
                write_q <= cmd_write;
                error   <= 1'b0;
                idx     <= 4'h0;
                op      <= 2'd0;
            end
            case (state)
                S_LOAD: begin
                    eng_write_byte <= op_byte;
                    eng_read_mode  <= op_read_mode;
                    eng_do_start   <= op_start;
                    eng_expect_ack <= op_ack;
                    eng_do_stop    <= op_stop;
                    eng_clock      <= 1'b0;
                    toggles        <= '0;
                    half_cnt       <= HW'(HALF_PERIOD - 1);
                end
                S_RUN: begin
                    if (!half_expire) begin
                        half_cnt <= half_cnt - 1'b1;
                    end else begin
                        half_cnt <= HW'(HALF_PERIOD - 1);
                        if (op_done) begin
                            if (!write_q && op == 2'd3) addr_q <= addr_q + 8'd1;
                        end else if (op_timeout) begin
                            error          <= 1'b1;
                            eng_clock      <= 1'b0;
                            eng_write_byte <= 8'h00;
                            eng_read_mode  <= 1'b0;
                            eng_do_start   <= 1'b0;
                            eng_expect_ack <= 1'b0;
                            eng_do_stop    <= 1'b0;
                        end else begin
                            eng_clock <= ~eng_clock;
                            toggles   <= toggles + 1'b1;
                        end
                    end
                end
                S_NEXT: begin
                    if (last_op) begin
                        eng_clock      <= 1'b0;
                        eng_write_byte <= 8'h00;
                        eng_read_mode  <= 1'b0;
                        eng_do_start   <= 1'b0;
                        eng_expect_ack <= 1'b0;
                        eng_do_stop    <= 1'b0;
                        twr_cnt        <= TWW'(TWR_CYCLES - 1);
                    end else if (seq_end) begin
                        idx <= idx + 4'd1;
                        op  <= write_q ? 2'd2 : 2'd0;
                    end else begin
                        op <= op + 2'd1;
                    end
                end
                S_TWR: twr_cnt <= twr_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Buffers hold their contents across reset.
    always_ff @(posedge clock) begin
        if (buf_wr_en && !(busy && write_q))
            wr_buf[buf_wr_addr] <= buf_wr_data;
        if (reset_n && state == S_RUN && op_done && !write_q && op == 2'd3)
            rd_buf[idx] <= eng_read_byte;
    end
endmodule

// File: tb/tb_i2c_eeprom_sequencer.sv
// tb/tb_i2c_eeprom_sequencer.sv - directed self-checking bench for i2c_eeprom_sequencer
module tb_i2c_eeprom_sequencer;
    localparam int HP  = 4;
    localparam int TWR = 50;
    localparam int TT  = 16;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_start = 1'b0;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [3:0] cmd_count = 4'h0;
    logic [2:0] dev_sel = 3'b000;
    logic       buf_wr_en = 1'b0;
    logic [3:0] buf_wr_addr = 4'h0;
    logic [7:0] buf_wr_data = 8'h00;
    logic [3:0] buf_rd_addr = 4'h0;
    logic [7:0] buf_rd_data;
    logic       busy, done, error, eng_clock;
    logic [7:0] eng_write_byte;
    logic       eng_read_mode, eng_do_start, eng_expect_ack, eng_do_stop;
    logic [7:0] eng_read_byte = 8'h00;
    logic       eng_finished = 1'b0;

    i2c_eeprom_sequencer #(
        .HALF_PERIOD(HP), .TWR_CYCLES(TWR), .TIMEOUT_TOGGLES(TT)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_count(cmd_count), .dev_sel(dev_sel),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .busy(busy), .done(done), .error(error), .eng_clock(eng_clock),
        .eng_write_byte(eng_write_byte), .eng_read_mode(eng_read_mode),
        .eng_do_start(eng_do_start), .eng_expect_ack(eng_expect_ack),
        .eng_do_stop(eng_do_stop), .eng_read_byte(eng_read_byte),
        .eng_finished(eng_finished)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    // Engine model: an op completes on its second rising eng_clock edge.
    logic       hold_off = 1'b0;
    int         model_cnt = 0;
    int         n_reads = 0;
    logic [7:0] rd_base = 8'h00;
    logic [7:0] log_byte [64];
    logic [3:0] log_flags [64];
    int         log_n = 0;

    always @(posedge eng_clock) begin
        if (eng_finished) begin
            eng_finished = 1'b0;
            model_cnt = 0;
        end
        model_cnt++;
        if (!hold_off && model_cnt == 2) begin
            if (log_n < 64) begin
                log_byte[log_n]  = eng_write_byte;
                log_flags[log_n] = {eng_read_mode, eng_do_start, eng_expect_ack, eng_do_stop};
                log_n++;
            end
            if (eng_read_mode) begin
                eng_read_byte = rd_base + 8'(n_reads);
                n_reads++;
            end
            eng_finished = 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_cmd(input logic w, input logic [7:0] a, input logic [3:0] c, input logic [2:0] d);
        log_n = 0;
        n_reads = 0;
        model_cnt = 0;
        @(negedge clock);
        cmd_write = w; cmd_addr = a; cmd_count = c; dev_sel = d; cmd_start = 1'b1;
        @(negedge clock);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_at_done"}, busy, 0);
        @(negedge clock);
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    logic [7:0] wdat [4];
    logic [7:0] expw [6];

    initial begin
        int n, twr_n, tg, first, last, bad;
        logic prev, seen;

        wdat = '{8'h11, 8'h22, 8'h33, 8'h44};
        expw = '{8'hAA, 8'h20, 8'h11, 8'h22, 8'h33, 8'h44};

        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_eng_clock", eng_clock, 0);
        check("rst_controls", {eng_write_byte, eng_read_mode, eng_do_start, eng_expect_ack, eng_do_stop}, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // single read
        rd_base = 8'hA5;
        start_cmd(1'b0, 8'h10, 4'd0, 3'b000);
        wait_done("rd1");
        check("rd1_ops", log_n, 4);
        check("rd1_devw", log_byte[0], 8'hA0);
        check("rd1_addr", log_byte[1], 8'h10);
        check("rd1_devr", log_byte[2], 8'hA1);
        check("rd1_flags_a", log_flags[0], 4'h6);
        check("rd1_flags_b", log_flags[1], 4'h2);
        check("rd1_flags_c", log_flags[2], 4'h6);
        check("rd1_flags_d", log_flags[3], 4'h9);
        buf_rd_addr = 4'd0; #1;
        check("rd1_buf0", buf_rd_data, 8'hA5);

        // sequential read across the 0xFF -> 0x00 wrap
        rd_base = 8'h30;
        start_cmd(1'b0, 8'hFE, 4'd2, 3'b000);
        wait_done("rdw");
        check("rdw_ops", log_n, 12);
        check("rdw_addr0", log_byte[1], 8'hFE);
        check("rdw_addr1", log_byte[5], 8'hFF);
        check("rdw_addr2", log_byte[9], 8'h00);
        for (int i = 0; i < 3; i++) begin
            buf_rd_addr = 4'(i); #1;
            check($sformatf("rdw_buf%0d", i), buf_rd_data, 8'h30 + 8'(i));
        end

        // page write with a busy-time command and buffer write that must be ignored
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            buf_wr_en = 1'b1; buf_wr_addr = 4'(i); buf_wr_data = wdat[i];
        end
        @(negedge clock);
        buf_wr_en = 1'b0;
        start_cmd(1'b1, 8'h20, 4'd3, 3'b101);
        repeat (3) @(negedge clock);
        cmd_start = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h55;
        buf_wr_en = 1'b1; buf_wr_addr = 4'd0; buf_wr_data = 8'hEE;
        @(negedge clock);
        cmd_start = 1'b0; buf_wr_en = 1'b0;
        n = 0; twr_n = 0;
        while (!done && n < 5000) begin
            if (busy && !eng_expect_ack) twr_n++;
            @(negedge clock);
            n++;
        end
        check("wr_done", done, 1);
        check("wr_twr_cycles", twr_n, TWR);
        check("wr_ops", log_n, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("wr_byte%0d", i), log_byte[i], expw[i]);
            check($sformatf("wr_stop%0d", i), log_flags[i][0], (i == 5) ? 1 : 0);
        end
        @(negedge clock);
        check("wr_no_restart", busy, 0);
        start_cmd(1'b1, 8'h20, 4'd0, 3'b000);
        wait_done("wr2");
        check("wr2_buf_kept", log_byte[2], 8'h11);

        // timeout with the engine never finishing; also checks engine clock timing
        hold_off = 1'b1;
        start_cmd(1'b0, 8'h00, 4'd0, 3'b000);
        n = 0; tg = 0; first = -1; last = 0; bad = 0; prev = eng_clock;
        while (!done && n < 5000) begin
            @(negedge clock);
            n++;
            if (eng_clock !== prev) begin
                tg++;
                if (tg == 1) first = n;
                else if (n - last != HP) bad++;
                last = n;
                prev = eng_clock;
            end
        end
        check("to_done", done, 1);
        check("to_error", error, 1);
        check("to_eng_clock", eng_clock, 0);
        check("to_controls", {eng_write_byte, eng_read_mode, eng_do_start, eng_expect_ack, eng_do_stop}, 0);
        check("to_toggles", tg, TT);
        check("first_rise", first, HP + 1);
        check("half_period", bad, 0);
        @(negedge clock);
        check("to_error_sticky", error, 1);
        hold_off = 1'b0;
        start_cmd(1'b0, 8'h00, 4'd0, 3'b000);
        check("to_error_cleared", error, 0);
        wait_done("after_to");

        // reset in the middle of RUN
        start_cmd(1'b0, 8'h40, 4'd0, 3'b000);
        repeat (6) @(negedge clock);
        check("mid_busy", busy, 1);
        reset_n = 1'b0;
        @(negedge clock);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_eng_clock", eng_clock, 0);
        check("mr_controls", {eng_write_byte, eng_read_mode, eng_do_start, eng_expect_ack, eng_do_stop}, 0);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        check("mr_no_done", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
